// File: rtl/write_audio.sv
// Writer side of the audio sample FIFO: deserializes I2S audio in the wclock domain
// and pushes {left, right} sample pairs into the dual-clock FIFO, counting dropped words.
`timescale 1ns/1ps
module write_audio #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned OVF_WIDTH   = 8
) (
    input  logic                       wclock,
    input  logic                       reset,
    input  logic                       bclk,
    input  logic                       lrck,
    input  logic                       sdata,
    input  logic                       wrfull,
    output logic                       wrreq,
    output logic [2*SAMPLE_BITS-1:0]   data,
    output logic                       locked,
    output logic [OVF_WIDTH-1:0]       overflow_count
);

    localparam int unsigned SLOT_W = 6;
    localparam int unsigned WORD_W = 2 * SAMPLE_BITS;
    localparam logic [SLOT_W-1:0] SLOT_MAX = '1;
    localparam logic [SLOT_W-1:0] LAST_BIT = SLOT_W'(SAMPLE_BITS);
    localparam logic [SLOT_W-1:0] MIN_LEFT = SLOT_W'(SAMPLE_BITS + 1);

    typedef enum logic [2:0] {
        SYNC      = 3'd0,
        LEFT      = 3'd1,
        RIGHT     = 3'd2,
        COMMIT    = 3'd3,
        WAIT_LEFT = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [2:0]             bclk_sync;
    logic [1:0]             lrck_sync;
    logic [1:0]             sdata_sync;
    logic                   lr_prev;
    logic [SLOT_W-1:0]      slot_cnt;
    logic [SLOT_W-1:0]      cur_slot;
    logic [SAMPLE_BITS-1:0] left_sr;
    logic [SAMPLE_BITS-1:0] right_sr;

    logic                   bit_tick;
    logic                   lr_now;
    logic                   sd_now;
    logic                   lr_change;
    logic                   lr_rise;
    logic                   lr_fall;
    logic                   data_slot;
    logic                   shift_left;
    logic                   shift_right;

    logic                   wrreq_d;
    logic [WORD_W-1:0]      data_d;
    logic                   locked_d;
    logic [OVF_WIDTH-1:0]   ovf_d;

    // Input synchronizers; the third bclk stage feeds the rising-edge detector.
    always_ff @(posedge wclock or posedge reset) begin
        if (reset) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            sdata_sync <= '0;
        end else begin
            bclk_sync  <= {bclk_sync[1:0], bclk};
            lrck_sync  <= {lrck_sync[0], lrck};
            sdata_sync <= {sdata_sync[0], sdata};
        end
    end

    assign bit_tick  = bclk_sync[1] & ~bclk_sync[2];
    assign lr_now    = lrck_sync[1];
    assign sd_now    = sdata_sync[1];
    assign lr_change = bit_tick && (lr_now != lr_prev);
    assign lr_rise   = lr_change && lr_now;
    assign lr_fall   = lr_change && !lr_now;

    // Slot index of the bit being sampled at this tick: 0 on a word-select change, else saturating +1.
    assign cur_slot    = lr_change ? '0 :
                         ((slot_cnt == SLOT_MAX) ? SLOT_MAX : slot_cnt + SLOT_W'(1));
    assign data_slot   = (cur_slot != '0) && (cur_slot <= LAST_BIT);
    assign shift_left  = bit_tick && data_slot && (state_q == LEFT);
    assign shift_right = bit_tick && data_slot && (state_q == RIGHT);

    always_ff @(posedge wclock or posedge reset) begin
        if (reset) begin
            lr_prev  <= 1'b0;
            slot_cnt <= '0;
            left_sr  <= '0;
            right_sr <= '0;
        end else begin
            if (bit_tick) begin
                lr_prev  <= lr_now;
                slot_cnt <= cur_slot;
            end
            if (shift_left) begin
                left_sr <= {left_sr[SAMPLE_BITS-2:0], sd_now};
            end
            if (shift_right) begin
                right_sr <= {right_sr[SAMPLE_BITS-2:0], sd_now};
            end
        end
    end

    // Frame tracking and FIFO write decision.
    always_comb begin
        state_d  = state_q;
        wrreq_d  = 1'b0;
        data_d   = data;
        locked_d = locked;
        ovf_d    = overflow_count;
        case (state_q)
            SYNC: begin
                if (lr_fall) state_d = LEFT;
            end
            LEFT: begin
                if (lr_rise) begin
                    if (slot_cnt >= MIN_LEFT) begin
                        state_d = RIGHT;
                    end else begin
                        state_d  = SYNC;
                        locked_d = 1'b0;
                    end
                end
            end
            RIGHT: begin
                if (lr_fall) begin
                    state_d  = SYNC;
                    locked_d = 1'b0;
                end else if (bit_tick && (cur_slot == LAST_BIT)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (!wrfull) begin
                    wrreq_d  = 1'b1;
                    data_d   = {left_sr, right_sr};
                    locked_d = 1'b1;
                end else if (overflow_count != '1) begin
                    ovf_d = overflow_count + OVF_WIDTH'(1);
                end
                state_d = WAIT_LEFT;
            end
            WAIT_LEFT: begin
                if (lr_fall) state_d = LEFT;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge wclock or posedge reset) begin
        if (reset) begin
            state_q        <= SYNC;
            wrreq          <= 1'b0;
            data           <= '0;
            locked         <= 1'b0;
            overflow_count <= '0;
        end else begin
            state_q        <= state_d;
            wrreq          <= wrreq_d;
            data           <= data_d;
            locked         <= locked_d;
            overflow_count <= ovf_d;
        end
    end

endmodule
